screen_writer: RTL

SCREEN_WRITER -- requirements
Module: screen_writer

---
 rtl/screen_pkg.sv | 8 +
 rtl/screen_addr.sv | 17 +
 rtl/screen_writer.sv | 95 +++++++++
 3 files changed

// File: rtl/screen_pkg.sv
// screen_pkg: screen geometry and the opcode and state encodings shared by the writer.
package screen_pkg;
    localparam int COLS = 40;
    localparam int ROWS = 30;
    localparam int AW = 11;
    typedef enum logic [1:0] {OP_WRITE, OP_FILL, OP_FILLROW, OP_RSVD} op_t;
    typedef enum logic [1:0] {IDLE, WRITE, FILL} state_t;
endpackage

// File: rtl/screen_addr.sv
// screen_addr: row-major character address, row*COLS+col.
module screen_addr #(
    parameter int COLS = screen_pkg::COLS
) (
    input  logic [4:0]  row,
    input  logic [5:0]  col,
    output logic [10:0] addr
);
    logic [10:0] r;
    logic [10:0] c;
    always_comb begin
        r = {6'd0, row};
        c = {5'd0, col};
        // The 40-column screen needs only two shifts and an add.
        addr = (COLS == 40) ? (r << 5) + (r << 3) + c : r * 11'(COLS) + c;
    end
endmodule

// File: rtl/screen_writer.sv
// screen_writer: turns write/fill/fill-row commands into a stream of screen-memory writes.
module screen_writer
    import screen_pkg::*;
#(
    parameter int COLS  = screen_pkg::COLS,
    parameter int ROWS  = screen_pkg::ROWS,
    parameter int CBITS = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [4:0]       cmd_row,
    input  logic [5:0]       cmd_col,
    input  logic [CBITS-1:0] cmd_char,
    output logic             smem_we,
    output logic [10:0]      smem_addr,
    output logic [CBITS-1:0] smem_wdata,
    output logic             busy,
    output logic             err
);
    state_t           state;
    state_t           state_next;
    op_t              op;
    logic [10:0]      addr;
    logic [10:0]      last;
    logic [CBITS-1:0] data;
    logic [10:0]      row_start;
    logic [10:0]      row_end;
    logic [10:0]      start_addr;
    logic [10:0]      end_addr;
    logic             accept;
    logic             bad;

    assign op = op_t'(cmd_op);

    screen_addr #(.COLS(COLS)) u_start (
        .row  (cmd_row),
        .col  (op == OP_WRITE ? cmd_col : 6'd0),
        .addr (row_start)
    );

    screen_addr #(.COLS(COLS)) u_end (
        .row  (cmd_row),
        .col  (6'(COLS - 1)),
        .addr (row_end)
    );

    always_comb begin
        accept     = cmd_valid && cmd_ready;
        bad        = (op == OP_RSVD) || (op != OP_FILL && cmd_row >= 5'(ROWS))
                     || (op == OP_WRITE && cmd_col >= 6'(COLS));
        start_addr = (op == OP_FILL) ? 11'd0 : row_start;
        end_addr   = (op == OP_FILL) ? 11'(ROWS * COLS - 1) : row_end;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            addr  <= '0;
            last  <= '0;
            data  <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            err   <= accept && bad;
            if (accept) begin
                addr <= start_addr;
                last <= end_addr;
                data <= cmd_char;
            end else if (state == FILL && addr != last) begin
                addr <= addr + 11'd1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = (accept && !bad) ? (op == OP_WRITE ? WRITE : FILL) : IDLE;
            WRITE:   state_next = IDLE;
            FILL:    state_next = (addr == last) ? IDLE : FILL;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready  = state == IDLE;
        busy       = state != IDLE;
        smem_we    = state != IDLE;
        smem_addr  = addr;
        smem_wdata = data;
    end
endmodule
